udp_tx_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares the single 512-bit UDP stack TX AXI-Stream path between NUM_PORTS user sources.
- Grants one source at a time and holds the grant until that source's tlast beat is accepted, so packets are never interleaved.
- Drives the stack TX input through one registered output stage; sits directly upstream of the stack's s_axis TX interface.

---
 rtl/udp_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// Packet-level round-robin arbiter that feeds the UDP stack TX AXI-Stream input through one output register.
// Define TX_ARB_PKT_CNT_EN to enable the per-port forwarded-packet counters on pkt_cnt.
module udp_tx_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                          axis_clk,
  input  logic                          axis_rst,
  input  logic [NUM_PORTS-1:0]          s_axis_tvalid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]          s_axis_tlast,
  output logic [NUM_PORTS-1:0]          s_axis_tready,
  output logic                          m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [2:0]                    grant_id,
  output logic                          busy,
  output logic [NUM_PORTS*32-1:0]       pkt_cnt
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] next_grant;
  logic [IDX_W-1:0] idx_sel;
  int unsigned      idx;
  logic             found;
  logic             sel_valid;
  logic             sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic             out_free;
  logic             xfer;

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    next_grant = grant_q;
    found      = 1'b0;
    idx        = 0;
    idx_sel    = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx     = (32'(last_grant) + i) % NUM_PORTS;
      idx_sel = IDX_W'(idx);
      if (!found && s_axis_tvalid[idx_sel]) begin
        found      = 1'b1;
        next_grant = idx_sel;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
      end
    end
  end

  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign xfer     = (state == BUSY) && sel_valid && out_free;

  always_comb begin
    s_axis_tready = '0;
    if (state == BUSY) s_axis_tready[grant_q] = out_free;
  end

  always_comb begin
    grant_id              = '0;
    grant_id[IDX_W-1:0]   = grant_q;
  end

  assign busy = (state == BUSY);

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state         <= IDLE;
      grant_q       <= '0;
      last_grant    <= IDX_W'(NUM_PORTS - 1);
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_q <= next_grant;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (xfer && sel_last) begin
            last_grant <= grant_q;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (xfer) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= sel_data;
        m_axis_tkeep  <= sel_keep;
        m_axis_tlast  <= sel_last;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef TX_ARB_PKT_CNT_EN
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      pkt_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (xfer && sel_last && grant_q == IDX_W'(i))
          pkt_cnt[i*32 +: 32] <= pkt_cnt[i*32 +: 32] + 32'd1;
      end
    end
  end
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed self-checking bench for udp_tx_arbiter (4 ports, 512-bit data).
module tb_udp_tx_arbiter;

  logic            clk = 1'b0;
  logic            axis_rst;
  logic [3:0]      s_tvalid, s_tlast, s_tready;
  logic [2047:0]   s_tdata;
  logic [255:0]    s_tkeep;
  logic            m_tvalid, m_tlast, m_tready;
  logic [511:0]    m_tdata;
  logic [63:0]     m_tkeep;
  logic [2:0]      grant_id;
  logic            busy;
  logic [127:0]    pkt_cnt;

  udp_tx_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(512), .KEEP_WIDTH(64)) dut (
    .axis_clk(clk), .axis_rst(axis_rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0, total = 0, cyc = 0;
  int unsigned npk[4], len[4], beat[4], pk[4];
  logic [63:0] base[4], lkeep[4];
  logic [63:0] od[$], ok[$];
  logic        ol[$];
  int unsigned oc[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cfg(int p, int unsigned n, int unsigned l, logic [63:0] b);
    npk[p] = n; len[p] = l; base[p] = b; pk[p] = 0; beat[p] = 0; lkeep[p] = '1;
  endtask

  // Each source presents base + 16*packet + beat; tlast on the final beat.
  task automatic drive();
    for (int p = 0; p < 4; p++) begin
      s_tvalid[p]            = (npk[p] != 0);
      s_tdata[p*512 +: 512]  = 512'(base[p] + 64'(pk[p]*16 + beat[p]));
      s_tlast[p]             = (beat[p] == len[p] - 1);
      s_tkeep[p*64 +: 64]    = s_tlast[p] ? lkeep[p] : '1;
    end
  endtask

  task automatic step();
    logic [3:0] hs;
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      od.push_back(m_tdata[63:0]); ok.push_back(m_tkeep); ol.push_back(m_tlast); oc.push_back(cyc);
    end
    @(posedge clk); #1; cyc++;
    for (int p = 0; p < 4; p++) begin
      if (hs[p]) begin
        if (beat[p] == len[p] - 1) begin beat[p] = 0; pk[p]++; npk[p]--; end
        else beat[p]++;
      end
    end
    drive();
  endtask

  task automatic clear_q();
    od.delete(); ok.delete(); ol.delete(); oc.delete(); cyc = 0;
  endtask

  task automatic do_reset();
    axis_rst = 1'b1; m_tready = 1'b1;
    for (int p = 0; p < 4; p++) cfg(p, 0, 1, 64'(p*256));
    drive();
    @(posedge clk); #1;
    axis_rst = 1'b0;
    clear_q();
  endtask

  task automatic drain(string tag);
    int unsigned n = 0;
    while ((npk[0] + npk[1] + npk[2] + npk[3] != 0 || m_tvalid || busy) && n < 200) begin
      step(); n++;
    end
    chk({tag, "_done"}, 64'(n < 200), 64'd1);
  endtask

  initial begin
    // Reset state and idle
    axis_rst = 1'b1; m_tready = 1'b1;
    for (int p = 0; p < 4; p++) cfg(p, 0, 1, 64'(p*256));
    drive();
    #2;
    chk("rst_mvalid", 64'(m_tvalid), 0);
    chk("rst_sready", 64'(s_tready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_grant", 64'(grant_id), 0);
    chk("rst_mdata", 64'(|m_tdata), 0);
    chk("rst_cnt", 64'(|pkt_cnt), 0);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_mvalid", 64'(m_tvalid), 0);
      chk("idle_busy", 64'(busy), 0);
    end
    chk("idle_sready", 64'(s_tready), 0);

    // Port 1, three beats, last keep 0xFFFF
    do_reset();
    cfg(1, 1, 3, 64'h11); lkeep[1] = 64'hFFFF; drive();
    step();
    chk("t2_busy", 64'(busy), 1);
    chk("t2_grant", 64'(grant_id), 1);
    chk("t2_mvalid0", 64'(m_tvalid), 0);
    chk("t2_sready", 64'(s_tready), 64'b0010);
    step();
    chk("t2_mvalid1", 64'(m_tvalid), 1);
    chk("t2_d0", m_tdata[63:0], 64'h11);
    chk("t2_k0", m_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2_l0", 64'(m_tlast), 0);
    step();
    chk("t2_d1", m_tdata[63:0], 64'h12);
    step();
    chk("t2_d2", m_tdata[63:0], 64'h13);
    chk("t2_k2", m_tkeep, 64'hFFFF);
    chk("t2_l2", 64'(m_tlast), 1);
    chk("t2_hi", 64'(|m_tdata[511:64]), 0);
    chk("t2_idle", 64'(busy), 0);
    step();
    chk("t2_mvalid_end", 64'(m_tvalid), 0);

    // All four ports, two 2-beat packets each: round robin 0,1,2,3,0,1,2,3
    do_reset();
    for (int p = 0; p < 4; p++) cfg(p, 2, 2, 64'(p*256));
    drive();
    drain("t3");
    chk("t3_count", 64'(od.size()), 16);
    if (od.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk("t3_data", od[i], 64'(((i/2)%4)*256 + ((i/2)/4)*16 + (i%2)));
        chk("t3_last", 64'(ol[i]), 64'(i%2));
      end
      for (int n = 0; n < 7; n++) chk("t3_gap", 64'(oc[2*n+2] - oc[2*n+1]), 2);
    end

    // Port 2, four beats, m_tready 1,0,0,1 after grant
    do_reset();
    cfg(2, 1, 4, 64'h200); drive();
    step();
    chk("t4_grant", 64'(grant_id), 2);
    chk("t4_sready_a", 64'(s_tready), 64'b0100);
    step();
    m_tready = 1'b0; #1;
    chk("t4_sready_stall1", 64'(s_tready), 0);
    chk("t4_d0", m_tdata[63:0], 64'h200);
    step();
    chk("t4_hold1", m_tdata[63:0], 64'h200);
    chk("t4_hold1_v", 64'(m_tvalid), 1);
    chk("t4_sready_stall2", 64'(s_tready), 0);
    step();
    chk("t4_hold2", m_tdata[63:0], 64'h200);
    m_tready = 1'b1; #1;
    chk("t4_sready_b", 64'(s_tready), 64'b0100);
    drain("t4");
    chk("t4_count", 64'(od.size()), 4);
    if (od.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t4_data", od[i], 64'(32'h200 + i));
        chk("t4_last", 64'(ol[i]), 64'(i == 3));
      end

    // Reset during beat 2 of a 5-beat packet from port 3
    do_reset();
    cfg(3, 1, 5, 64'h300); drive();
    step();
    chk("t5_grant3", 64'(grant_id), 3);
    step();
    step();
    chk("t5_d1", m_tdata[63:0], 64'h301);
    axis_rst = 1'b1; #1;
    chk("t5_mvalid", 64'(m_tvalid), 0);
    chk("t5_mdata", 64'(|m_tdata), 0);
    chk("t5_mkeep", m_tkeep, 0);
    chk("t5_mlast", 64'(m_tlast), 0);
    chk("t5_busy", 64'(busy), 0);
    chk("t5_grant", 64'(grant_id), 0);
    chk("t5_sready", 64'(s_tready), 0);
    @(posedge clk); #1;
    axis_rst = 1'b0;
    clear_q();
    cfg(0, 1, 1, 64'h0A0); cfg(3, 1, 1, 64'h3F0); drive();
    step();
    chk("t5_first", 64'(grant_id), 0);
    chk("t5_busy2", 64'(busy), 1);
    drain("t5");
    chk("t5_count", 64'(od.size()), 2);
    if (od.size() == 2) begin
      chk("t5_o0", od[0], 64'h0A0);
      chk("t5_o1", od[1], 64'h3F0);
    end

    // Packet counters: five from port 0, two from port 3
    do_reset();
    cfg(0, 5, 1, 64'h0); cfg(3, 2, 1, 64'h300); drive();
    drain("t6");
    chk("t6_count", 64'(od.size()), 7);
`ifdef TX_ARB_PKT_CNT_EN
    chk("t6_cnt0", 64'(pkt_cnt[31:0]), 5);
    chk("t6_cnt1", 64'(pkt_cnt[63:32]), 0);
    chk("t6_cnt2", 64'(pkt_cnt[95:64]), 0);
    chk("t6_cnt3", 64'(pkt_cnt[127:96]), 2);
`else
    chk("t6_cnt_lo", pkt_cnt[63:0], 0);
    chk("t6_cnt_hi", pkt_cnt[127:64], 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
